// File: rtl/fp_result_buffer.sv
// Result buffer behind the 3-stage FP multiplier: aligns issue tags to the product,
// queues products in a small FIFO and steps through them with a debounced-free push-button.
module fp_result_buffer #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int LAT    = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_issue,
   input  logic [31:0]       i_product,
   input  logic              i_step_n,
   output logic [31:0]       o_result,
   output logic [1:0]        o_class,
   output logic [ADDR_W:0]   o_count,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_overrun
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   // IEEE-754 single-precision class: 00 zero/denormal, 01 normal, 10 inf, 11 NaN
   function automatic logic [1:0] fp_class(input logic [31:0] v);
      logic [7:0]  e;
      logic [22:0] f;
      e = v[30:23];
      f = v[22:0];
      if (e == 8'h00)
         fp_class = 2'b00;
      else if (e == 8'hFF)
         fp_class = (f == '0) ? 2'b10 : 2'b11;
      else
         fp_class = 2'b01;
   endfunction

   logic [LAT-1:0]    tag_p;
   logic              tag_out;
   logic              key_s1, key_s2, key_h;
   logic              step;
   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count;
   logic              overrun;
   logic              full, empty;
   logic              push, pop;

   // Stage p0..p(LAT-1): issue tag travels alongside the multiplier pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_p <= '0;
      end else begin
         tag_p[0] <= i_issue;
         for (int i = 1; i < LAT; i++)
            tag_p[i] <= tag_p[i-1];
      end
   end

   assign tag_out = tag_p[LAT-1];

   // Button synchronizer and falling-edge detect; released state is 1
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
         key_h  <= 1'b1;
      end else begin
         key_s1 <= i_step_n;
         key_s2 <= key_s1;
         key_h  <= key_s2;
      end
   end

   assign step  = key_h & ~key_s2;
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign pop   = step & ~empty;
   assign push  = tag_out & (~full | pop);

   // Storage is data only and carries no reset
   always_ff @(posedge clk) begin
      if (rst_n && push)
         mem[wr_ptr] <= i_product;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (tag_out && full && !pop)
            overrun <= 1'b1;
      end
   end

   assign o_result  = empty ? 32'h0 : mem[rd_ptr];
   assign o_class   = fp_class(o_result);
   assign o_count   = count;
   assign o_full    = full;
   assign o_empty   = empty;
   assign o_overrun = overrun;

endmodule

// File: tb/tb_fp_result_buffer.sv
// Bench for fp_result_buffer: directed test-plan steps followed by random traffic,
// all checked each cycle against a queue-based model driven by edge-indexed history.
module tb_fp_result_buffer;

   localparam int DEPTH = 8;
   localparam int HIST  = 8192;

   logic        clk;
   logic        rst_n;
   logic        i_issue;
   logic [31:0] i_product;
   logic        i_step_n;
   logic [31:0] o_result;
   logic [1:0]  o_class;
   logic [3:0]  o_count;
   logic        o_full;
   logic        o_empty;
   logic        o_overrun;

   fp_result_buffer #(.DEPTH(8), .ADDR_W(3), .LAT(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_issue   (i_issue),
      .i_product (i_product),
      .i_step_n  (i_step_n),
      .o_result  (o_result),
      .o_class   (o_class),
      .o_count   (o_count),
      .o_full    (o_full),
      .o_empty   (o_empty),
      .o_overrun (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: what was sampled at each rising edge, plus the queued products
   bit          iss_h [HIST];
   bit          key_h [HIST];
   int          edge_n;
   logic [31:0] q[$];
   bit          m_ovr;

   function automatic logic [1:0] ref_class(input logic [31:0] v);
      int e;
      e = int'(v[30:23]);
      if (e == 0)        return 2'd0;
      if (e == 255)      return (v[22:0] == 0) ? 2'd2 : 2'd3;
      return 2'd1;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [31:0] er;
      er = (q.size() != 0) ? q[0] : 32'h0;
      chk("result",  o_result,  er);
      chk("class",   32'(o_class), 32'(ref_class(er)));
      chk("count",   32'(o_count), 32'(q.size()));
      chk("full",    32'(o_full),  32'(q.size() == DEPTH));
      chk("empty",   32'(o_empty), 32'(q.size() == 0));
      chk("overrun", 32'(o_overrun), 32'(m_ovr));
   endtask

   // One clock: model reacts to the edge, outputs are checked on the falling edge
   task automatic cycle();
      bit tag, want_pop;
      @(posedge clk);
      edge_n++;
      if (edge_n >= HIST) begin
         $display("FAIL cycle_budget: observed %0d expected <%0d", edge_n, HIST);
         $fatal(1, "cycle budget exhausted");
      end
      iss_h[edge_n] = i_issue;
      key_h[edge_n] = i_step_n;
      if (!rst_n) begin
         q.delete();
         m_ovr = 1'b0;
         for (int d = 0; d < 3; d++) begin
            iss_h[edge_n-d] = 1'b0;
            key_h[edge_n-d] = 1'b1;
         end
      end else begin
         tag      = iss_h[edge_n-3];
         want_pop = !key_h[edge_n-2] && key_h[edge_n-3];
         if (want_pop && q.size() != 0)
            void'(q.pop_front());
         if (tag) begin
            if (q.size() < DEPTH) q.push_back(i_product);
            else                  m_ovr = 1'b1;
         end
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic press(input int hold);
      i_step_n = 1'b0;
      repeat (hold) cycle();
      i_step_n = 1'b1;
      repeat (4) cycle();
   endtask

   task automatic push_list(input logic [31:0] vals[16], input int n);
      for (int c = 0; c < n + 3; c++) begin
         i_issue   = (c < n);
         i_product = (c >= 3) ? vals[c-3] : $urandom;
         cycle();
      end
      i_issue = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   logic [31:0] vals [16];
   logic [31:0] r;

   initial begin
      for (int i = 0; i < HIST; i++) begin
         iss_h[i] = 1'b0;
         key_h[i] = 1'b1;
      end
      edge_n = 3;
      m_ovr  = 1'b0;
      rst_n = 1'b0; i_issue = 1'b0; i_product = '0; i_step_n = 1'b1;
      @(negedge clk);
      cycle();
      cycle();
      chk("rst_count", 32'(o_count), 0);
      chk("rst_empty", 32'(o_empty), 1);
      chk("rst_full", 32'(o_full), 0);
      chk("rst_result", o_result, 0);
      chk("rst_overrun", 32'(o_overrun), 0);
      rst_n = 1'b1;

      // Single issue lands exactly LAT edges later
      i_issue = 1'b1; cycle();
      i_issue = 1'b0; cycle(); cycle();
      chk("t1_not_early", 32'(o_count), 0);
      i_product = 32'h40C00000; cycle();
      chk("t1_count", 32'(o_count), 1);
      chk("t1_result", o_result, 32'h40C00000);
      chk("t1_class", 32'(o_class), 1);
      i_product = 32'h12345678; cycle();
      chk("t1_no_extra", 32'(o_count), 1);
      press(1);
      chk("t1_popped", 32'(o_count), 0);

      // Nine issues into an empty FIFO: the ninth overruns
      for (int k = 0; k < 9; k++) vals[k] = 32'h3F800000 + k;
      push_list(vals, 9);
      chk("t2_full", 32'(o_full), 1);
      chk("t2_overrun", 32'(o_overrun), 1);
      chk("t2_head", o_result, 32'h3F800000);
      press(2);
      chk("t2_sticky", 32'(o_overrun), 1);
      chk("t2_count", 32'(o_count), 7);
      do_reset();
      chk("t2_cleared", 32'(o_overrun), 0);

      // Full FIFO, pop and push on the same edge
      push_list(vals, 8);
      chk("t3_full", 32'(o_count), 8);
      i_issue = 1'b1; cycle();
      i_issue = 1'b0; i_step_n = 1'b0; cycle();
      i_step_n = 1'b1; cycle();
      i_product = 32'h40490FDB; cycle();
      chk("t3_count", 32'(o_count), 8);
      chk("t3_overrun", 32'(o_overrun), 0);
      chk("t3_head", o_result, 32'h3F800001);
      repeat (4) cycle();
      for (int k = 0; k < 7; k++) press(1);
      chk("t3_tail", o_result, 32'h40490FDB);
      press(1);

      // Long hold pops exactly once, on the third edge
      do_reset();
      push_list(vals, 3);
      i_step_n = 1'b0;
      cycle(); cycle();
      chk("t4_before", 32'(o_count), 3);
      cycle();
      chk("t4_third", 32'(o_count), 2);
      repeat (17) cycle();
      i_step_n = 1'b1;
      repeat (4) cycle();
      chk("t4_once", 32'(o_count), 2);
      press(1); press(1);
      press(3);
      chk("t4_empty_res", o_result, 0);
      chk("t4_empty_cls", 32'(o_class), 0);
      chk("t4_empty_cnt", 32'(o_count), 0);

      // Class codes and pointer wrap
      vals[0] = 32'h7F800000; vals[1] = 32'h7FC00000; vals[2] = 32'h00000000;
      push_list(vals, 3);
      chk("t5_inf", 32'(o_class), 2);
      press(1);
      chk("t5_nan", 32'(o_class), 3);
      press(1);
      chk("t5_zero", 32'(o_class), 0);
      chk("t5_cnt", 32'(o_count), 1);
      press(1);
      for (int k = 0; k < 20; k++) begin
         vals[0] = $urandom;
         push_list(vals, 1);
         press(1);
      end

      // Reset with stored and in-flight products
      for (int k = 0; k < 5; k++) vals[k] = $urandom;
      push_list(vals, 5);
      i_issue = 1'b1; cycle(); cycle();
      i_issue = 1'b0;
      do_reset();
      chk("t6_count", 32'(o_count), 0);
      chk("t6_empty", 32'(o_empty), 1);
      chk("t6_overrun", 32'(o_overrun), 0);
      repeat (4) cycle();
      chk("t6_no_push", 32'(o_count), 0);

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         r = $urandom;
         case ($urandom_range(0, 7))
            0: r[30:23] = 8'h00;
            1: r[30:23] = 8'hFF;
            2: r[30:0]  = '0;
            default: ;
         endcase
         i_product = r;
         i_issue   = ($urandom_range(0, 99) < 45);
         if ($urandom_range(0, 5) == 0) i_step_n = ~i_step_n;
         rst_n = ($urandom_range(0, 199) != 0);
         cycle();
      end
      rst_n = 1'b1;
      i_issue = 1'b0;
      i_step_n = 1'b1;
      repeat (6) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_result_buffer.md
Name: fp_result_buffer

Overview:
Downstream consumer of the 3-stage single-precision FP multiplier.
- Tracks which multiplier input cycles carried a real operand pair, using a valid tag pipeline matched to the multiplier latency.
- Captures each aligned product into a small FIFO.
- Lets the operator step through the buffered results with a push-button.
- The FIFO head drives the board displays, together with a 2-bit IEEE class code and occupancy/status flags.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two).
- ADDR_W, 3, log2(DEPTH).
- LAT, 3, latency in clk cycles from multiplier operand input to product output.

Ports:
- clk  input  1  system clock (the divided board clock); all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- i_issue  input  1  high in any cycle in which a valid operand pair is presented to the multiplier inputs.
- i_product  input  32  multiplier product output.
- i_step_n  input  1  raw active-low push-button (KEY); asynchronous to clk.
- o_result  output  32  FIFO head entry; 0 when empty.
- o_class  output  2  class of o_result: 00 zero/denormal, 01 normal, 10 infinity, 11 NaN.
- o_count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- o_full  output  1  o_count == DEPTH.
- o_empty  output  1  o_count == 0.
- o_overrun  output  1  sticky; set when a product arrives while the FIFO is full and cannot be stored.

Behaviour:
Reset:
- Reset is sampled only on the rising edge of clk while rst_n == 0.
- Cleared: valid tag pipeline, read/write pointers, count, overrun.
- Key synchronizer flops and edge-detect history are preset to 1 (button released).
- FIFO storage is not reset.
- Resulting outputs: o_result = 0, o_class = 00, o_count = 0, o_empty = 1, o_full = 0, o_overrun = 0.
- Reset asserted mid-operation discards all buffered and in-flight results. No push or pop occurs on the reset edge.

Valid alignment:
- A LAT-deep shift register shifts i_issue in every cycle.
- Tap tag_out = stage LAT-1 output, i.e. i_issue delayed LAT cycles.
- i_issue high before edge N makes tag_out high during cycle N+LAT-1.
- That entry is pushed at edge N+LAT, capturing i_product at that edge. This aligns with the multiplier's 3-register path.

Step input:
- Two-flop synchronizer s1 -> s2, then a history flop h <= s2.
- step = h & ~s2: one-cycle pulse on the falling edge of the button.
- The pop takes effect at the 3rd rising edge after i_step_n goes low, provided setup is met.
- Exactly one pop per press, regardless of hold time. The release edge does nothing.

FIFO:
- push = tag_out & (~full | pop).
- pop = step & ~empty.
- Push writes mem[wr_ptr] and increments wr_ptr, wrapping modulo DEPTH.
- Pop increments rd_ptr, wrapping modulo DEPTH.
- Push only: count +1. Pop only: count -1. Both: count unchanged.
- Full with simultaneous pop and product: both happen, count stays DEPTH, no overrun.
- Empty with simultaneous pop and product: the pop is ignored and the push occurs.
- tag_out & full & ~pop: product dropped, o_overrun <= 1; it stays 1 until reset.
- Step while empty: no effect.

Outputs:
- o_result = mem[rd_ptr] when ~empty, else 32'h0. Combinational from state; updates in the cycle after the push/pop edge.
- o_class is decoded from o_result:
  - exp == 0 -> 00
  - exp == 8'hFF and frac == 0 -> 10
  - exp == 8'hFF and frac != 0 -> 11
  - otherwise -> 01
- o_full and o_empty are derived from o_count.
- All outputs are glitch-free with respect to register state. There are no combinational paths from i_product or i_issue to any output.

Test Plan:
1. Reset, then i_issue = 1 for the single cycle before edge 0, with i_product = 32'h40C00000 at edge 3 (2.0 x 3.0) -> after edge 3: o_empty = 0, o_count = 1, o_result = 32'h40C00000, o_class = 01. Nothing is pushed at edges 1-2 or 4.
2. Nine consecutive issues with no steps, products 32'h3F800000 + k -> o_full = 1 after the 8th push; the 9th is dropped and o_overrun = 1; o_result = 32'h3F800000. o_overrun stays 1 through later steps until rst_n = 0.
3. Full FIFO, product arrives in the same cycle as a step pulse -> count stays 8, o_overrun stays 0, o_result advances to entry 1, and the new product lands in the slot vacated by the pop.
4. Hold i_step_n low for 20 cycles with 3 entries -> exactly one pop, at the 3rd edge after the fall; o_count 3 -> 2. A step while empty -> no change, o_result = 0, o_class = 00.
5. Push 32'h7F800000, 32'h7FC00000, 32'h00000000 and step through -> o_class reads 10, 11, 00. Wrap-around: 20 push/pop pairs -> data order preserved across the pointer wrap.
6. Assert rst_n = 0 with 5 entries stored and 2 products in flight -> after the edge: o_count = 0, o_empty = 1, o_overrun = 0; no pushes at the following LAT edges.
